// File: rtl/regression_pkg.sv
// Shared types and helpers for the regression sequencer: FSM state encoding,
// default sizing constants and packed-slot offset helpers.
package regression_pkg;

    localparam int ELEM_WIDTH_DEF  = 14;
    localparam int NUM_SAMPLES_DEF = 3;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_X,
        LOAD_Y,
        TRANSPOSE,
        MULT,
        INVERT,
        FINAL,
        DONE,
        ERROR
    } seq_state_t;

    // Bit offset of the intercept element (constant 1) of design-matrix row `row`.
    function automatic int one_slot_offset(input int row, input int width);
        return 2 * row * width;
    endfunction

    // Bit offset of the x element of design-matrix row `row`.
    function automatic int x_slot_offset(input int row, input int width);
        return (2 * row + 1) * width;
    endfunction

    // Bit offset of target element `row` in the packed y vector.
    function automatic int y_slot_offset(input int row, input int width);
        return row * width;
    endfunction

    // States in which the sequencer is waiting on a datapath stage.
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == TRANSPOSE) || (s == MULT) || (s == INVERT) || (s == FINAL);
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog counter: cleared on entry to a wait state, counts while
// enabled, and flags expiry in the LIMIT-th cycle spent waiting.
module stage_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count up while enabled, saturating at LIMIT.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CW'(LIMIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry depends only on registered count so it never loops through the FSM's next state.
    assign expired_o = enable_i && (count_q >= CW'(LIMIT - 1));

endmodule

// File: rtl/regression_sequencer.sv
// Control FSM for the least-squares regression datapath: collects (x, y)
// samples, packs the design matrix and target vector, and sequences the
// transpose / multiply / inverse / final stages.
// Optional per-stage watchdog enabled by defining REGRESSION_WATCHDOG_EN.
module regression_sequencer
    import regression_pkg::*;
#(
    parameter int ELEM_WIDTH     = ELEM_WIDTH_DEF,
    parameter int NUM_SAMPLES    = NUM_SAMPLES_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enter,
    input  logic [ELEM_WIDTH-1:0]               data_in,
    input  logic                                input_done,
    output logic [NUM_SAMPLES*2*ELEM_WIDTH-1:0] x_data,
    output logic [NUM_SAMPLES*ELEM_WIDTH-1:0]   y_data,
    output logic                                ready,
    output logic                                start_transpose,
    output logic                                start_mult,
    output logic                                start_inverse,
    output logic                                start_final,
    input  logic                                done_transpose,
    input  logic                                done_xtx,
    input  logic                                done_xty,
    input  logic                                done_inverse,
    input  logic                                done_final,
    input  logic                                invalid,
    output logic                                busy,
    output logic                                result_valid,
    output logic                                error_values,
    output logic                                error_det,
    output logic                                error_timeout
);

    localparam int XW    = NUM_SAMPLES * 2 * ELEM_WIDTH;
    localparam int YW    = NUM_SAMPLES * ELEM_WIDTH;
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             xtx_seen_q, xtx_seen_d;
    logic             xty_seen_q, xty_seen_d;
    logic             err_values_q, err_values_d;
    logic             err_det_q, err_det_d;
    logic             err_timeout_q, err_timeout_d;
    logic             start_transpose_q, start_mult_q, start_inverse_q, start_final_q;
    logic             ready_q, busy_q, result_valid_q;
    logic             wd_expired;

`ifdef REGRESSION_WATCHDOG_EN
    logic wd_clear;
    logic wd_enable;

    // Restart the count on every state change so each wait state gets a fresh budget.
    assign wd_clear  = (state_d != state_q);
    assign wd_enable = is_wait_state(state_q);

    stage_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_stage_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expired_o(wd_expired)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expired = 1'b0;
`endif

    // Next-state logic: sample capture, stage handshakes and error handling.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        xtx_seen_d    = xtx_seen_q;
        xty_seen_d    = xty_seen_q;
        err_values_d  = err_values_q;
        err_det_d     = err_det_q;
        err_timeout_d = err_timeout_q;

        unique case (state_q)
            IDLE, LOAD_X: begin
                if (input_done) begin
                    err_values_d = 1'b1;
                    state_d      = ERROR;
                end else if (enter) begin
                    x_d[one_slot_offset(int'(cnt_q), ELEM_WIDTH) +: ELEM_WIDTH] = ELEM_WIDTH'(1);
                    x_d[x_slot_offset(int'(cnt_q), ELEM_WIDTH) +: ELEM_WIDTH]   = data_in;
                    state_d = LOAD_Y;
                end
            end
            LOAD_Y: begin
                if (input_done) begin
                    err_values_d = 1'b1;
                    state_d      = ERROR;
                end else if (enter) begin
                    y_d[y_slot_offset(int'(cnt_q), ELEM_WIDTH) +: ELEM_WIDTH] = data_in;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(NUM_SAMPLES)) begin
                        state_d = TRANSPOSE;
                    end else begin
                        state_d = LOAD_X;
                    end
                end
            end
            TRANSPOSE: begin
                if (done_transpose) begin
                    xtx_seen_d = 1'b0;
                    xty_seen_d = 1'b0;
                    state_d    = MULT;
                end else if (wd_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ERROR;
                end
            end
            MULT: begin
                // The two multiplies finish independently; remember each until both are in.
                xtx_seen_d = xtx_seen_q | done_xtx;
                xty_seen_d = xty_seen_q | done_xty;
                if (xtx_seen_d && xty_seen_d) begin
                    state_d = INVERT;
                end else if (wd_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ERROR;
                end
            end
            INVERT: begin
                if (done_inverse) begin
                    if (invalid) begin
                        err_det_d = 1'b1;
                        state_d   = ERROR;
                    end else begin
                        state_d = FINAL;
                    end
                end else if (wd_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ERROR;
                end
            end
            FINAL: begin
                if (done_final) begin
                    state_d = DONE;
                end else if (wd_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ERROR;
                end
            end
            DONE, ERROR: begin
                // A new enter starts a fresh run with this value as x_0.
                if (enter) begin
                    err_values_d  = 1'b0;
                    err_det_d     = 1'b0;
                    err_timeout_d = 1'b0;
                    cnt_d         = '0;
                    x_d           = '0;
                    y_d           = '0;
                    x_d[one_slot_offset(0, ELEM_WIDTH) +: ELEM_WIDTH] = ELEM_WIDTH'(1);
                    x_d[x_slot_offset(0, ELEM_WIDTH) +: ELEM_WIDTH]   = data_in;
                    state_d = LOAD_Y;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; outputs are registered from the next state so
    // start pulses appear in the first cycle of their state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            x_q               <= '0;
            y_q               <= '0;
            xtx_seen_q        <= 1'b0;
            xty_seen_q        <= 1'b0;
            err_values_q      <= 1'b0;
            err_det_q         <= 1'b0;
            err_timeout_q     <= 1'b0;
            start_transpose_q <= 1'b0;
            start_mult_q      <= 1'b0;
            start_inverse_q   <= 1'b0;
            start_final_q     <= 1'b0;
            ready_q           <= 1'b1;
            busy_q            <= 1'b0;
            result_valid_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            x_q               <= x_d;
            y_q               <= y_d;
            xtx_seen_q        <= xtx_seen_d;
            xty_seen_q        <= xty_seen_d;
            err_values_q      <= err_values_d;
            err_det_q         <= err_det_d;
            err_timeout_q     <= err_timeout_d;
            start_transpose_q <= (state_d == TRANSPOSE) && (state_q != TRANSPOSE);
            start_mult_q      <= (state_d == MULT) && (state_q != MULT);
            start_inverse_q   <= (state_d == INVERT) && (state_q != INVERT);
            start_final_q     <= (state_d == FINAL) && (state_q != FINAL);
            ready_q           <= (state_d == IDLE) || (state_d == LOAD_X) || (state_d == LOAD_Y);
            busy_q            <= is_wait_state(state_d);
            result_valid_q    <= (state_d == DONE);
        end
    end

    assign x_data          = x_q;
    assign y_data          = y_q;
    assign ready           = ready_q;
    assign start_transpose = start_transpose_q;
    assign start_mult      = start_mult_q;
    assign start_inverse   = start_inverse_q;
    assign start_final     = start_final_q;
    assign busy            = busy_q;
    assign result_valid    = result_valid_q;
    assign error_values    = err_values_q;
    assign error_det       = err_det_q;
    assign error_timeout   = err_timeout_q;

endmodule

// File: tb/tb_regression_sequencer.sv
// Self-checking bench for regression_sequencer: directed and randomized runs
// against a cycle-schedule / packing reference model.
module tb_regression_sequencer;

    localparam int W  = 14;
    localparam int N  = 3;
    localparam int TO = 16;
    localparam int XW = N * 2 * W;
    localparam int YW = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enter = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          input_done = 1'b0;
    logic          done_transpose = 1'b0;
    logic          done_xtx = 1'b0;
    logic          done_xty = 1'b0;
    logic          done_inverse = 1'b0;
    logic          done_final = 1'b0;
    logic          invalid = 1'b0;
    logic [XW-1:0] x_data;
    logic [YW-1:0] y_data;
    logic          ready, busy, result_valid;
    logic          start_transpose, start_mult, start_inverse, start_final;
    logic          error_values, error_det, error_timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model of the loaded samples.
    int sx [N];
    int sy [N];
    int mx [N];
    int my [N];
    int m_nx;
    int m_ny;

    always #5 clk = ~clk;

    regression_sequencer #(
        .ELEM_WIDTH    (W),
        .NUM_SAMPLES   (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enter          (enter),
        .data_in        (data_in),
        .input_done     (input_done),
        .x_data         (x_data),
        .y_data         (y_data),
        .ready          (ready),
        .start_transpose(start_transpose),
        .start_mult     (start_mult),
        .start_inverse  (start_inverse),
        .start_final    (start_final),
        .done_transpose (done_transpose),
        .done_xtx       (done_xtx),
        .done_xty       (done_xty),
        .done_inverse   (done_inverse),
        .done_final     (done_final),
        .invalid        (invalid),
        .busy           (busy),
        .result_valid   (result_valid),
        .error_values   (error_values),
        .error_det      (error_det),
        .error_timeout  (error_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        enter          = 1'b0;
        input_done     = 1'b0;
        done_transpose = 1'b0;
        done_xtx       = 1'b0;
        done_xty       = 1'b0;
        done_inverse   = 1'b0;
        done_final     = 1'b0;
        invalid        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
        m_nx = 0;
        m_ny = 0;
    endtask

    // Expected packed design matrix: row i = {x_i, 1}, unloaded rows zero.
    function automatic logic [XW-1:0] exp_x();
        logic [XW-1:0] v;
        v = '0;
        for (int i = 0; i < m_nx; i++) begin
            v[(2 * i) * W +: W]     = W'(1);
            v[(2 * i + 1) * W +: W] = W'(mx[i]);
        end
        return v;
    endfunction

    function automatic logic [YW-1:0] exp_y();
        logic [YW-1:0] v;
        v = '0;
        for (int i = 0; i < m_ny; i++) v[i * W +: W] = W'(my[i]);
        return v;
    endfunction

    // Enter npairs samples from sx/sy; ends in the cycle after the last accepted value.
    task automatic load_pairs(input int npairs, input bit gaps);
        m_nx = 0;
        m_ny = 0;
        for (int i = 0; i < npairs; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (gaps) repeat ($urandom_range(0, 2)) tick();
                if (!(i == 0 && k == 0)) begin
                    checks++;
                    if (ready !== 1'b1) begin
                        failures++;
                        $display("FAIL load_ready pair=%0d k=%0d got=%b want=1", i, k, ready);
                    end
                end
                enter   = 1'b1;
                data_in = (k == 0) ? W'(sx[i]) : W'(sy[i]);
                tick();
                enter = 1'b0;
                if (k == 0) begin
                    mx[i] = sx[i];
                    m_nx++;
                end else begin
                    my[i] = sy[i];
                    m_ny++;
                end
            end
        end
    endtask

    // Drives the stage done inputs on a computed schedule starting at cycle 0 and
    // checks start pulse timing, busy/ready/result_valid shape, flags and packing.
    task automatic run_stages(input string name, input int lt, input int la, input int lb,
                              input int li, input int lf, input bit inv, input bit noise);
        int dt, sm, da, db, si, di, sf, df, fin, last, quiet;
        int n_st, n_sm, n_si, n_sf, f_st, f_sm, f_si, f_sf, f_rv;
        int busy_bad, ready_bad, rv_bad;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        dt = lt;
        sm = dt + 1;
        da = sm + la;
        db = sm + lb;
        si = ((da > db) ? da : db) + 1;
        di = si + li;
        if (inv) begin
            sf  = -1;
            df  = -1;
            fin = di + 1;
        end else begin
            sf  = di + 1;
            df  = sf + lf;
            fin = df + 1;
        end
        quiet = fin - 1;
        last  = fin + 2;
        n_st = 0; n_sm = 0; n_si = 0; n_sf = 0;
        f_st = -1; f_sm = -1; f_si = -1; f_sf = -1; f_rv = -1;
        busy_bad = 0; ready_bad = 0; rv_bad = 0;
        ex = exp_x();
        ey = exp_y();

        checks++;
        if (x_data !== ex || y_data !== ey) begin
            failures++;
            $display("FAIL %s_packing x=%h want %h y=%h want %h", name, x_data, ex, y_data, ey);
        end

        for (int c = 0; c <= last; c++) begin
            if (start_transpose === 1'b1) begin n_st++; if (f_st < 0) f_st = c; end
            if (start_mult === 1'b1)      begin n_sm++; if (f_sm < 0) f_sm = c; end
            if (start_inverse === 1'b1)   begin n_si++; if (f_si < 0) f_si = c; end
            if (start_final === 1'b1)     begin n_sf++; if (f_sf < 0) f_sf = c; end
            if (result_valid === 1'b1 && f_rv < 0) f_rv = c;
            if (busy !== (c < fin)) busy_bad++;
            if (ready !== 1'b0) ready_bad++;
            if (result_valid !== (!inv && c >= fin)) rv_bad++;

            done_transpose = (c == dt) || (noise && c > dt && $urandom_range(0, 3) == 0);
            done_xtx       = (c == da) || (noise && c < sm && $urandom_range(0, 3) == 0);
            done_xty       = (c == db) || (noise && c < sm && $urandom_range(0, 3) == 0);
            done_inverse   = (c == di) || (noise && c < si && $urandom_range(0, 3) == 0);
            invalid        = (c == di) ? inv : ($urandom_range(0, 1) == 1);
            done_final     = (!inv && c == df) ||
                             (noise && c < (inv ? fin : sf) && $urandom_range(0, 3) == 0);
            enter          = noise && c < quiet && $urandom_range(0, 3) == 0;
            input_done     = noise && c < quiet && $urandom_range(0, 3) == 0;
            data_in        = W'($urandom_range(0, (1 << W) - 1));
            tick();
        end
        clear_inputs();

        checks++;
        if (n_st != 1 || f_st != 0) begin
            failures++;
            $display("FAIL %s_start_transpose count=%0d first=%0d want 1 at 0", name, n_st, f_st);
        end
        checks++;
        if (n_sm != 1 || f_sm != sm) begin
            failures++;
            $display("FAIL %s_start_mult count=%0d first=%0d want 1 at %0d", name, n_sm, f_sm, sm);
        end
        checks++;
        if (n_si != 1 || f_si != si) begin
            failures++;
            $display("FAIL %s_start_inverse count=%0d first=%0d want 1 at %0d", name, n_si, f_si, si);
        end
        checks++;
        if (n_sf != (inv ? 0 : 1) || f_sf != sf) begin
            failures++;
            $display("FAIL %s_start_final count=%0d first=%0d want %0d at %0d",
                     name, n_sf, f_sf, inv ? 0 : 1, sf);
        end
        checks++;
        if (f_rv != (inv ? -1 : fin) || rv_bad != 0) begin
            failures++;
            $display("FAIL %s_result_valid first=%0d bad=%0d want first %0d", name, f_rv, rv_bad,
                     inv ? -1 : fin);
        end
        checks++;
        if (busy_bad != 0 || ready_bad != 0) begin
            failures++;
            $display("FAIL %s_busy_ready busy_bad=%0d ready_bad=%0d want 0/0", name, busy_bad, ready_bad);
        end
        checks++;
        if (error_det !== inv || error_values !== 1'b0 || error_timeout !== 1'b0) begin
            failures++;
            $display("FAIL %s_flags det=%b val=%b to=%b want det=%b val=0 to=0",
                     name, error_det, error_values, error_timeout, inv);
        end
        checks++;
        if (x_data !== ex || y_data !== ey) begin
            failures++;
            $display("FAIL %s_data_hold x=%h want %h y=%h want %h", name, x_data, ex, y_data, ey);
        end
        $display("run %s lat=%0d/%0d/%0d/%0d/%0d inv=%0b starts t=%0d m=%0d i=%0d f=%0d rv=%0d",
                 name, lt, la, lb, li, lf, inv, f_st, f_sm, f_si, f_sf, f_rv);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (x_data !== '0 || y_data !== '0 || ready !== 1'b1 || busy !== 1'b0 ||
            result_valid !== 1'b0 || start_transpose !== 1'b0 || start_mult !== 1'b0 ||
            start_inverse !== 1'b0 || start_final !== 1'b0 || error_values !== 1'b0 ||
            error_det !== 1'b0 || error_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_values x=%h y=%h rdy=%b busy=%b rv=%b st=%b%b%b%b err=%b%b%b want rdy=1 rest 0",
                     x_data, y_data, ready, busy, result_valid, start_transpose, start_mult,
                     start_inverse, start_final, error_values, error_det, error_timeout);
        end
        $display("reset check done");
    endtask

    task automatic test_nominal();
        logic [XW-1:0] hand_x;
        logic [YW-1:0] hand_y;
        do_reset();
        sx[0] = 2; sx[1] = 5; sx[2] = 8;
        sy[0] = 3; sy[1] = 6; sy[2] = 9;
        load_pairs(N, 1'b0);
        hand_x = {W'(8), W'(1), W'(5), W'(1), W'(2), W'(1)};
        hand_y = {W'(9), W'(6), W'(3)};
        checks++;
        if (x_data !== hand_x || y_data !== hand_y) begin
            failures++;
            $display("FAIL nominal_literal x=%h want %h y=%h want %h", x_data, hand_x, y_data, hand_y);
        end
        run_stages("nominal", 1, 1, 1, 1, 1, 1'b0, 1'b0);
        // input_done in DONE is ignored
        input_done = 1'b1;
        tick();
        input_done = 1'b0;
        tick();
        checks++;
        if (error_values !== 1'b0 || result_valid !== 1'b1) begin
            failures++;
            $display("FAIL done_ignores_input_done val=%b rv=%b want 0/1", error_values, result_valid);
        end
    endtask

    task automatic test_early_end();
        int st_seen;
        do_reset();
        input_done = 1'b1;
        tick();
        input_done = 1'b0;
        checks++;
        if (error_values !== 1'b1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL early_end_idle err=%b rdy=%b want 1/0", error_values, ready);
        end
        do_reset();
        for (int i = 0; i < N; i++) begin
            sx[i] = $urandom_range(0, (1 << W) - 1);
            sy[i] = $urandom_range(0, (1 << W) - 1);
        end
        load_pairs(N - 1, 1'b1);
        input_done = 1'b1;
        tick();
        input_done = 1'b0;
        st_seen = 0;
        checks++;
        if (error_values !== 1'b1 || ready !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL early_end_flags err=%b rdy=%b busy=%b rv=%b want 1/0/0/0",
                     error_values, ready, busy, result_valid);
        end
        checks++;
        if (x_data !== exp_x() || y_data !== exp_y()) begin
            failures++;
            $display("FAIL early_end_partial x=%h want %h y=%h want %h", x_data, exp_x(), y_data, exp_y());
        end
        for (int c = 0; c < 6; c++) begin
            if (start_transpose === 1'b1) st_seen++;
            tick();
        end
        checks++;
        if (st_seen != 0) begin
            failures++;
            $display("FAIL early_end_no_transpose pulses=%0d want 0", st_seen);
        end
        $display("early end: error_values=%b", error_values);
    endtask

    task automatic test_singular();
        do_reset();
        for (int i = 0; i < N; i++) begin
            sx[i] = 4;
            sy[i] = $urandom_range(0, (1 << W) - 1);
        end
        load_pairs(N, 1'b0);
        run_stages("singular", 1, 1, 1, 1, 1, 1'b1, 1'b0);
        enter   = 1'b1;
        data_in = W'(7);
        tick();
        enter = 1'b0;
        m_nx  = 1;
        m_ny  = 0;
        mx[0] = 7;
        checks++;
        if (error_det !== 1'b0 || error_values !== 1'b0 || ready !== 1'b1 ||
            x_data !== exp_x() || y_data !== '0) begin
            failures++;
            $display("FAIL singular_restart det=%b val=%b rdy=%b x=%h want %h y=%h want 0",
                     error_det, error_values, ready, x_data, exp_x(), y_data);
        end
    endtask

    task automatic test_skew();
        do_reset();
        for (int i = 0; i < N; i++) begin
            sx[i] = $urandom_range(0, (1 << W) - 1);
            sy[i] = $urandom_range(0, (1 << W) - 1);
        end
        load_pairs(N, 1'b0);
        run_stages("skew_xty_first", 1, 4, 1, 1, 1, 1'b0, 1'b0);
        load_pairs(N, 1'b0);
        run_stages("skew_same_cycle", 1, 2, 2, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                sx[i] = $urandom_range(0, (1 << W) - 1);
                sy[i] = $urandom_range(0, (1 << W) - 1);
            end
            load_pairs(N, 1'b1);
            run_stages("random", $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6),
                       $urandom_range(1, 6), $urandom_range(1, 6), ($urandom_range(0, 3) == 0), 1'b1);
        end
    endtask

    task automatic test_watchdog();
        int busy_bad, to_bad;
        do_reset();
        for (int i = 0; i < N; i++) begin
            sx[i] = i + 1;
            sy[i] = i + 2;
        end
        load_pairs(N, 1'b0);
        busy_bad = 0;
        to_bad   = 0;
`ifdef REGRESSION_WATCHDOG_EN
        for (int c = 0; c <= TO + 4; c++) begin
            if (error_timeout !== (c >= TO)) to_bad++;
            if (busy !== (c < TO)) busy_bad++;
            tick();
        end
`else
        for (int c = 0; c < 100; c++) begin
            if (error_timeout !== 1'b0) to_bad++;
            if (busy !== 1'b1) busy_bad++;
            tick();
        end
`endif
        checks++;
        if (to_bad != 0 || busy_bad != 0) begin
            failures++;
            $display("FAIL watchdog timeout_bad=%0d busy_bad=%0d want 0/0 (to=%b busy=%b now)",
                     to_bad, busy_bad, error_timeout, busy);
        end
        $display("watchdog: error_timeout=%b busy=%b", error_timeout, busy);
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        for (int i = 0; i < N; i++) begin
            sx[i] = $urandom_range(1, (1 << W) - 1);
            sy[i] = $urandom_range(1, (1 << W) - 1);
        end
        load_pairs(N, 1'b0);
        tick();                     // cycle 1
        done_transpose = 1'b1;
        tick();                     // cycle 2: MULT
        done_transpose = 1'b0;
        checks++;
        if (start_mult !== 1'b1) begin
            failures++;
            $display("FAIL midreset_in_mult start_mult=%b want 1", start_mult);
        end
        tick();                     // cycle 3: still MULT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (x_data !== '0 || y_data !== '0 || ready !== 1'b1 || busy !== 1'b0 ||
            start_mult !== 1'b0 || start_inverse !== 1'b0 || result_valid !== 1'b0 ||
            error_values !== 1'b0 || error_det !== 1'b0 || error_timeout !== 1'b0) begin
            failures++;
            $display("FAIL midreset_values x=%h y=%h rdy=%b busy=%b sm=%b si=%b rv=%b want reset values",
                     x_data, y_data, ready, busy, start_mult, start_inverse, result_valid);
        end
        done_xtx = 1'b1;
        done_xty = 1'b1;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || start_inverse !== 1'b0) begin
            failures++;
            $display("FAIL midreset_done_ignored rdy=%b busy=%b si=%b want 1/0/0", ready, busy, start_inverse);
        end
        $display("mid-run reset: ready=%b busy=%b", ready, busy);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_early_end();
        test_singular();
        test_skew();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout sim_time=%0t limit reached", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
